// File: rtl/videomem_pkg.sv
// Shared constants and types for the video-memory pixel write front end.
// The parser and writer state encodings are plain localparams so legacy tools can use them.
package videomem_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned BURST_LEN16 = 4;

  typedef logic [24:0] addr_t;

  typedef logic [2:0] parse_state_t;
  localparam parse_state_t PsHunt = 3'd0;
  localparam parse_state_t PsAdr0 = 3'd1;
  localparam parse_state_t PsAdr1 = 3'd2;
  localparam parse_state_t PsAdr2 = 3'd3;
  localparam parse_state_t PsLen0 = 3'd4;
  localparam parse_state_t PsLen1 = 3'd5;
  localparam parse_state_t PsData = 3'd6;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t WsIdle = 2'd0;
  localparam wr_state_t WsReq  = 2'd1;
  localparam wr_state_t WsXfer = 2'd2;

  // 24-bit byte-packet address to 16-bit-word SDRAM burst address, burst aligned.
  function automatic addr_t burst_addr(input logic [23:0] a);
    return {1'b0, a[23:2], 2'b00};
  endfunction

endpackage

// File: rtl/videomem_burst_buf.sv
// Ping-pong burst staging buffer: two bursts of BURST_WORDS 32-bit words with full flags,
// fill/drain pointers and per-buffer burst address and last-burst-of-packet tags.
module videomem_burst_buf
  import videomem_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 2,
  localparam int unsigned WidxW = $clog2(BURST_WORDS),
  localparam int unsigned BidxW = WidxW + 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fill_we_i,
  input  logic [BidxW-1:0] fill_idx_i,
  input  logic [7:0]       fill_byte_i,
  input  logic             fill_commit_i,
  input  addr_t            fill_addr_i,
  input  logic             fill_last_i,
  output logic             fill_full_o,
  input  logic [WidxW-1:0] drain_idx_i,
  input  logic             drain_free_i,
  output logic             drain_full_o,
  output logic [31:0]      drain_word_o,
  output addr_t            drain_addr_o,
  output logic             drain_last_o
);

  logic [1:0][BURST_WORDS-1:0][31:0] mem_q, mem_d;
  logic [1:0]                        full_q, full_d;
  logic [1:0]                        last_q, last_d;
  addr_t [1:0]                       addr_q, addr_d;
  logic                              fill_ptr_q, fill_ptr_d;
  logic                              drain_ptr_q, drain_ptr_d;

  always_comb begin
    mem_d       = mem_q;
    full_d      = full_q;
    last_d      = last_q;
    addr_d      = addr_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;

    // Bytes land little-endian: low byte index is the low byte of the word.
    if (fill_we_i) begin
      mem_d[fill_ptr_q][fill_idx_i[BidxW-1:2]][{fill_idx_i[1:0], 3'b000} +: 8] = fill_byte_i;
    end

    if (fill_commit_i) begin
      full_d[fill_ptr_q] = 1'b1;
      addr_d[fill_ptr_q] = fill_addr_i;
      last_d[fill_ptr_q] = fill_last_i;
      fill_ptr_d         = ~fill_ptr_q;
    end

    // Commit only targets an empty buffer and free only a full one, so they never collide.
    if (drain_free_i) begin
      full_d[drain_ptr_q] = 1'b0;
      drain_ptr_d         = ~drain_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q       <= '0;
      full_q      <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      full_q      <= full_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
    end
  end

  assign fill_full_o  = full_q[fill_ptr_q];
  assign drain_full_o = full_q[drain_ptr_q];
  assign drain_word_o = mem_q[drain_ptr_q][drain_idx_i];
  assign drain_addr_o = addr_q[drain_ptr_q];
  assign drain_last_o = last_q[drain_ptr_q];

endmodule

// File: rtl/videomem_wr_req.sv
// Packetised RGB565 pixel-write front end: parses A5-framed packets into SDRAM write bursts.
// Optional inter-byte timeout abort is enabled by defining VIDEOMEM_WR_TIMEOUT_EN.
module videomem_wr_req
  import videomem_pkg::*;
#(
  parameter int unsigned BURST_WORDS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        mem_clock,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_request,
  output logic [24:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        mem_req_ack,
  input  logic        give_next_data,
  output logic        pkt_done,
  output logic        sync_err
);

  localparam int unsigned WidxW = $clog2(BURST_WORDS);
  localparam int unsigned BidxW = WidxW + 2;
  localparam logic [WidxW-1:0] LastWidx = WidxW'(BURST_WORDS - 1);

  if (BURST_WORDS < 2 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("videomem_wr_req: BURST_WORDS must be >= 2 and TIMEOUT_CYCLES in 1..65535");
  end

  parse_state_t     ps_q, ps_d;
  logic [15:0]      a_lo_q, a_lo_d;
  addr_t            cur_addr_q, cur_addr_d;
  logic [15:0]      rem_q, rem_d;
  logic [BidxW-1:0] bcnt_q, bcnt_d;
  logic             pkt_done_q, pkt_done_d;
  logic             sync_err_q, sync_err_d;
  wr_state_t        ws_q, ws_d;
  logic [WidxW-1:0] widx_q, widx_d;

  logic        accept;
  logic        fill_we, fill_commit, fill_full;
  logic        drain_full, drain_last, drain_free;
  logic        empty_pkt;
  logic        wr_active;
  logic [31:0] drain_word;
  addr_t       drain_addr;

`ifdef VIDEOMEM_WR_TIMEOUT_EN
  localparam logic [15:0] GapMax = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] gap_q, gap_d;
`endif

  // Header bytes are always taken; payload only while the fill buffer has room.
  assign in_ready = (ps_q != PsData) | ~fill_full;
  assign accept   = in_valid & in_ready;

  always_comb begin
    ps_d        = ps_q;
    a_lo_d      = a_lo_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    bcnt_d      = bcnt_q;
    sync_err_d  = 1'b0;
    empty_pkt   = 1'b0;
    fill_we     = 1'b0;
    fill_commit = 1'b0;
`ifdef VIDEOMEM_WR_TIMEOUT_EN
    gap_d       = gap_q;
`endif

    if (accept) begin
      unique case (ps_q)
        PsHunt: begin
          if (in_data == SYNC_BYTE) ps_d = PsAdr0;
          else                      sync_err_d = 1'b1;
        end
        PsAdr0: begin
          a_lo_d[7:0] = in_data;
          ps_d        = PsAdr1;
        end
        PsAdr1: begin
          a_lo_d[15:8] = in_data;
          ps_d         = PsAdr2;
        end
        PsAdr2: begin
          cur_addr_d = burst_addr({in_data, a_lo_q});
          ps_d       = PsLen0;
        end
        PsLen0: begin
          rem_d[7:0] = in_data;
          ps_d       = PsLen1;
        end
        PsLen1: begin
          rem_d  = {in_data, rem_q[7:0]};
          bcnt_d = '0;
          if ({in_data, rem_q[7:0]} == 16'd0) begin
            ps_d      = PsHunt;
            empty_pkt = 1'b1;
          end else begin
            ps_d = PsData;
          end
        end
        PsData: begin
          fill_we = 1'b1;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == '1) begin
            fill_commit = 1'b1;
            cur_addr_d  = cur_addr_q + addr_t'(BURST_LEN16);
            rem_d       = rem_q - 16'd1;
            if (rem_q == 16'd1) ps_d = PsHunt;
          end
        end
        default: ps_d = PsHunt;
      endcase
    end

`ifdef VIDEOMEM_WR_TIMEOUT_EN
    // Abort drops the partial burst simply by restarting the byte counter.
    if (ps_q == PsHunt || accept) begin
      gap_d = '0;
    end else if (gap_q == GapMax) begin
      gap_d      = '0;
      ps_d       = PsHunt;
      bcnt_d     = '0;
      sync_err_d = 1'b1;
    end else begin
      gap_d = gap_q + 16'd1;
    end
`endif
  end

  // Request is raised combinationally in IDLE so it appears the cycle the buffer turns full.
  always_comb begin
    ws_d       = ws_q;
    widx_d     = widx_q;
    wr_request = 1'b0;
    drain_free = 1'b0;
    unique case (ws_q)
      WsIdle: begin
        if (drain_full && mem_ready) begin
          wr_request = 1'b1;
          widx_d     = '0;
          ws_d       = mem_req_ack ? WsXfer : WsReq;
        end
      end
      WsReq: begin
        wr_request = 1'b1;
        if (mem_req_ack) ws_d = WsXfer;
      end
      WsXfer: begin
        if (give_next_data) begin
          if (widx_q == LastWidx) begin
            drain_free = 1'b1;
            widx_d     = '0;
            ws_d       = WsIdle;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      default: ws_d = WsIdle;
    endcase
  end

  assign pkt_done_d = empty_pkt | (drain_free & drain_last);

  always_ff @(posedge mem_clock) begin
    if (reset) begin
      ps_q       <= PsHunt;
      a_lo_q     <= '0;
      cur_addr_q <= '0;
      rem_q      <= '0;
      bcnt_q     <= '0;
      pkt_done_q <= 1'b0;
      sync_err_q <= 1'b0;
      ws_q       <= WsIdle;
      widx_q     <= '0;
    end else begin
      ps_q       <= ps_d;
      a_lo_q     <= a_lo_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      bcnt_q     <= bcnt_d;
      pkt_done_q <= pkt_done_d;
      sync_err_q <= sync_err_d;
      ws_q       <= ws_d;
      widx_q     <= widx_d;
    end
  end

`ifdef VIDEOMEM_WR_TIMEOUT_EN
  always_ff @(posedge mem_clock) begin
    if (reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end
`endif

  videomem_burst_buf #(
    .BURST_WORDS(BURST_WORDS)
  ) u_buf (
    .clk_i        (mem_clock),
    .reset_i      (reset),
    .fill_we_i    (fill_we),
    .fill_idx_i   (bcnt_q),
    .fill_byte_i  (in_data),
    .fill_commit_i(fill_commit),
    .fill_addr_i  (cur_addr_q),
    .fill_last_i  (rem_q == 16'd1),
    .fill_full_o  (fill_full),
    .drain_idx_i  (widx_q),
    .drain_free_i (drain_free),
    .drain_full_o (drain_full),
    .drain_word_o (drain_word),
    .drain_addr_o (drain_addr),
    .drain_last_o (drain_last)
  );

  // Address and data read as zero whenever no burst is being offered or transferred.
  assign wr_active = wr_request | (ws_q == WsXfer);
  assign wr_addr   = wr_active ? drain_addr : '0;
  assign wr_data   = wr_active ? drain_word : '0;
  assign pkt_done  = pkt_done_q;
  assign sync_err  = sync_err_q;

endmodule
